pkt_fwd_mc: RTL and testbench

- CPU-configured multi-channel packet forwarder; next-generation, parametrised successor to the single-channel packet DUT.
- NUM_CH independent receive channels each buffer whole packets in a per-channel FIFO.
- An arbiter forwards complete packets one at a time onto a single transmit port.
- The CPU register port provides channel enables, status, and per-channel packet/drop counters.

---
 rtl/pkt_fwd_mc_pkg.sv | 25 ++
 rtl/pkt_chan_fifo.sv | 128 ++++++++++++
 rtl/pkt_fwd_mc.sv | 251 +++++++++++++++++++++++++
 tb/tb_pkt_fwd_mc.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pkt_fwd_mc_pkg.sv
// Shared definitions for the multi-channel packet forwarder:
// CPU register map, arbiter state encoding and the FIFO entry layout.
package pkt_fwd_mc_pkg;

    localparam int REG_CTRL        = 'h00;
    localparam int REG_STATUS      = 'h01;
    localparam int REG_PRIO        = 'h02;
    localparam int REG_RX_PKT_BASE = 'h10;
    localparam int REG_DROP_BASE   = 'h20;

    // Entry payload width; the forwarder's DATA_W must match this value.
    localparam int PKT_DATA_W = 8;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_SEND = 2'd1,
        ARB_GAP  = 2'd2
    } arb_state_t;

    typedef struct packed {
        logic                  last;
        logic [PKT_DATA_W-1:0] data;
    } fifo_entry_t;

endpackage

// File: rtl/pkt_chan_fifo.sv
// Per-channel receive framer and packet FIFO.
// A one-word hold register delays each word by a cycle so the final word can
// be tagged last when rx_vld falls. Writes advance a tentative pointer that is
// copied to the committed pointer only when the last word lands; an overflow
// rolls the tentative pointer back and discards the rest of the packet.
// The read side only ever sees committed (complete) packets.
module pkt_chan_fifo
    import pkt_fwd_mc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en_i,
    input  logic [DATA_W-1:0] rx_data_i,
    input  logic              rx_vld_i,
    input  logic              pop_i,
    output fifo_entry_t       rd_entry_o,
    output logic              pkt_avail_o,
    output logic              rx_pkt_o,
    output logic              drop_o
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int PW = AW + 1;

    fifo_entry_t       mem_q [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     cmt_ptr_q, cmt_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     pkt_cnt_q, pkt_cnt_d;
    logic              prev_vld_q;
    logic              accept_q, accept_d;
    logic [DATA_W-1:0] hold_q, hold_d;

    logic              push;
    fifo_entry_t       push_entry;
    logic              full;
    logic              pop_ok;
    logic              start;
    logic              pkt_end;

    assign full        = (wr_ptr_q - rd_ptr_q) == PW'(FIFO_DEPTH);
    assign pop_ok      = pop_i && (cmt_ptr_q != rd_ptr_q);
    assign start       = rx_vld_i && !prev_vld_q;
    assign pkt_end     = !rx_vld_i && prev_vld_q;
    assign rd_entry_o  = mem_q[rd_ptr_q[AW-1:0]];
    assign pkt_avail_o = (pkt_cnt_q != '0);

    // Framing, tentative write / commit / rollback and read pointer update.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        cmt_ptr_d  = cmt_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        accept_d   = accept_q;
        hold_d     = hold_q;
        push       = 1'b0;
        push_entry = '0;
        rx_pkt_o   = 1'b0;
        drop_o     = 1'b0;

        if (start) begin
            accept_d = en_i;
            hold_d   = rx_data_i;
        end else if (rx_vld_i && accept_q) begin
            if (full) begin
                wr_ptr_d = cmt_ptr_q;
                accept_d = 1'b0;
                drop_o   = 1'b1;
            end else begin
                push            = 1'b1;
                push_entry.last = 1'b0;
                push_entry.data = hold_q;
                wr_ptr_d        = wr_ptr_q + PW'(1);
                hold_d          = rx_data_i;
            end
        end else if (pkt_end && accept_q) begin
            accept_d = 1'b0;
            if (full) begin
                wr_ptr_d = cmt_ptr_q;
                drop_o   = 1'b1;
            end else begin
                push            = 1'b1;
                push_entry.last = 1'b1;
                push_entry.data = hold_q;
                wr_ptr_d        = wr_ptr_q + PW'(1);
                cmt_ptr_d       = wr_ptr_q + PW'(1);
                rx_pkt_o        = 1'b1;
            end
        end

        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        pkt_cnt_d = pkt_cnt_q + PW'(rx_pkt_o) - PW'(pop_ok && rd_entry_o.last);
    end

    // Storage array; contents need no reset since pointers gate every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_entry;
        end
    end

    // Pointer, framing and packet-count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            pkt_cnt_q  <= '0;
            prev_vld_q <= 1'b0;
            accept_q   <= 1'b0;
            hold_q     <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            cmt_ptr_q  <= cmt_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            pkt_cnt_q  <= pkt_cnt_d;
            prev_vld_q <= rx_vld_i;
            accept_q   <= accept_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: rtl/pkt_fwd_mc.sv
// Multi-channel packet forwarder: NUM_CH framed receive FIFOs, an arbiter
// sending one complete packet at a time to the tx port, and a CPU register
// file (channel enables, status, per-channel packet and drop counters).
// Optional build macro PKT_FWD_MC_PRIO_EN adds the PRIO register (strict
// lowest-index priority instead of round-robin when set).
//
// Arbiter states:
//   state    | meaning
//   ARB_IDLE | pick a ready channel; pop and present its first word
//   ARB_SEND | pop one word per cycle until the last-tagged word
//   ARB_GAP  | one idle tx cycle between packets
module pkt_fwd_mc
    import pkt_fwd_mc_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 4,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = 8,
    parameter int CPU_W      = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       sel,
    input  logic [ADDR_W-1:0]          addr,
    input  logic                       rw,
    input  logic [CPU_W-1:0]           din,
    output logic [CPU_W-1:0]           dout,
    input  logic [NUM_CH*DATA_W-1:0]   rxd,
    input  logic [NUM_CH-1:0]          rx_vld,
    output logic [DATA_W-1:0]          txd,
    output logic                       tx_vld,
    output logic [$clog2(NUM_CH)-1:0]  tx_ch
);

    localparam int CH_W = $clog2(NUM_CH);

    fifo_entry_t       rd_entry [NUM_CH];
    logic [NUM_CH-1:0] avail;
    logic [NUM_CH-1:0] rx_pkt;
    logic [NUM_CH-1:0] drop;
    logic [NUM_CH-1:0] pop;

    logic [NUM_CH-1:0] ch_en_q;
    logic [CPU_W-1:0]  rx_cnt_q [NUM_CH];
    logic [CPU_W-1:0]  rx_cnt_d [NUM_CH];
    logic [CPU_W-1:0]  drop_cnt_q [NUM_CH];
    logic [CPU_W-1:0]  drop_cnt_d [NUM_CH];
    logic [CPU_W-1:0]  dout_q, rdata_d;

    arb_state_t        state_q, state_d;
    logic [CH_W-1:0]   grant_q, grant_d;
    logic [CH_W-1:0]   rr_q, rr_d;
    logic [CH_W-1:0]   pick;
    logic [DATA_W-1:0] txd_q, txd_d;
    logic              tx_vld_q, tx_vld_d;
    logic [CH_W-1:0]   tx_ch_q, tx_ch_d;

    logic              wr_en;
    logic              rd_en;
    logic              unused_din;

`ifdef PKT_FWD_MC_PRIO_EN
    logic              prio_q;
`endif

    assign wr_en      = sel && rw;
    assign rd_en      = sel && !rw;
    assign unused_din = ^din[CPU_W-1:NUM_CH];

    assign dout   = dout_q;
    assign txd    = txd_q;
    assign tx_vld = tx_vld_q;
    assign tx_ch  = tx_ch_q;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pkt_chan_fifo #(
            .DATA_W     (DATA_W),
            .FIFO_DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk         (clk),
            .rst         (rst),
            .en_i        (ch_en_q[c]),
            .rx_data_i   (rxd[c*DATA_W +: DATA_W]),
            .rx_vld_i    (rx_vld[c]),
            .pop_i       (pop[c]),
            .rd_entry_o  (rd_entry[c]),
            .pkt_avail_o (avail[c]),
            .rx_pkt_o    (rx_pkt[c]),
            .drop_o      (drop[c])
        );
    end

    // Channel selection: round-robin from rr_q, or lowest ready index in
    // priority mode.
    always_comb begin
        logic          found;
        logic [CH_W-1:0] idx;
        pick  = rr_q;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = CH_W'((int'(rr_q) + i) % NUM_CH);
            if (!found && avail[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
`ifdef PKT_FWD_MC_PRIO_EN
        if (prio_q) begin
            for (int i = NUM_CH - 1; i >= 0; i--) begin
                if (avail[CH_W'(i)]) begin
                    pick = CH_W'(i);
                end
            end
        end
`endif
    end

    // Arbiter next-state, FIFO pop and registered tx outputs.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        txd_d    = txd_q;
        tx_vld_d = 1'b0;
        tx_ch_d  = tx_ch_q;
        pop      = '0;

        case (state_q)
            ARB_IDLE: begin
                if (|avail) begin
                    pop[pick] = 1'b1;
                    grant_d   = pick;
                    rr_d      = (int'(pick) == NUM_CH - 1) ? '0 : pick + CH_W'(1);
                    txd_d     = rd_entry[pick].data;
                    tx_vld_d  = 1'b1;
                    tx_ch_d   = pick;
                    state_d   = rd_entry[pick].last ? ARB_GAP : ARB_SEND;
                end
            end
            ARB_SEND: begin
                pop[grant_q] = 1'b1;
                txd_d        = rd_entry[grant_q].data;
                tx_vld_d     = 1'b1;
                tx_ch_d      = grant_q;
                if (rd_entry[grant_q].last) begin
                    state_d = ARB_GAP;
                end
            end
            ARB_GAP: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // Arbiter and tx registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ARB_IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            txd_q    <= '0;
            tx_vld_q <= 1'b0;
            tx_ch_q  <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            txd_q    <= txd_d;
            tx_vld_q <= tx_vld_d;
            tx_ch_q  <= tx_ch_d;
        end
    end

    // Saturating counters; a CPU write clears and wins over an increment.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            rx_cnt_d[c]   = rx_cnt_q[c];
            drop_cnt_d[c] = drop_cnt_q[c];
            if (wr_en && addr == ADDR_W'(REG_RX_PKT_BASE + c)) begin
                rx_cnt_d[c] = '0;
            end else if (rx_pkt[c] && !(&rx_cnt_q[c])) begin
                rx_cnt_d[c] = rx_cnt_q[c] + CPU_W'(1);
            end
            if (wr_en && addr == ADDR_W'(REG_DROP_BASE + c)) begin
                drop_cnt_d[c] = '0;
            end else if (drop[c] && !(&drop_cnt_q[c])) begin
                drop_cnt_d[c] = drop_cnt_q[c] + CPU_W'(1);
            end
        end
    end

    // Read mux; unmapped addresses return zero.
    always_comb begin
        rdata_d = '0;
        if (addr == ADDR_W'(REG_CTRL)) begin
            rdata_d[NUM_CH-1:0] = ch_en_q;
        end else if (addr == ADDR_W'(REG_STATUS)) begin
            rdata_d[NUM_CH-1:0] = avail;
        end
`ifdef PKT_FWD_MC_PRIO_EN
        if (addr == ADDR_W'(REG_PRIO)) begin
            rdata_d[0] = prio_q;
        end
`endif
        for (int c = 0; c < NUM_CH; c++) begin
            if (addr == ADDR_W'(REG_RX_PKT_BASE + c)) begin
                rdata_d = rx_cnt_q[c];
            end
            if (addr == ADDR_W'(REG_DROP_BASE + c)) begin
                rdata_d = drop_cnt_q[c];
            end
        end
    end

    // Register file state: enables, counters and held read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            ch_en_q <= '0;
            dout_q  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                rx_cnt_q[c]   <= '0;
                drop_cnt_q[c] <= '0;
            end
        end else begin
            if (wr_en && addr == ADDR_W'(REG_CTRL)) begin
                ch_en_q <= din[NUM_CH-1:0];
            end
            if (rd_en) begin
                dout_q <= rdata_d;
            end
            rx_cnt_q   <= rx_cnt_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

`ifdef PKT_FWD_MC_PRIO_EN
    // Arbitration mode bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio_q <= 1'b0;
        end else if (wr_en && addr == ADDR_W'(REG_PRIO)) begin
            prio_q <= din[0];
        end
    end
`endif

endmodule

// File: tb/tb_pkt_fwd_mc.sv
// Directed bench for pkt_fwd_mc with default parameters.
module tb_pkt_fwd_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic        sel;
    logic [7:0]  addr;
    logic        rw;
    logic [15:0] din;
    logic [15:0] dout;
    logic [31:0] rxd;
    logic [3:0]  rx_vld;
    logic [7:0]  txd;
    logic        tx_vld;
    logic [1:0]  tx_ch;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        int cyc;
        int ch;
        int data;
    } txw_t;

    txw_t txq[$];

    pkt_fwd_mc dut (
        .clk    (clk),
        .rst    (rst),
        .sel    (sel),
        .addr   (addr),
        .rw     (rw),
        .din    (din),
        .dout   (dout),
        .rxd    (rxd),
        .rx_vld (rx_vld),
        .txd    (txd),
        .tx_vld (tx_vld),
        .tx_ch  (tx_ch)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Transmit monitor, stamped with the cycle count after each edge.
    always @(posedge clk) begin
        #1;
        if (tx_vld === 1'b1) begin
            txq.push_back('{cyc, int'(tx_ch), int'(txd)});
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    function automatic txw_t txq_at(input int i);
        if (i < txq.size()) return txq[i];
        return '{-1, -1, -1};
    endfunction

    task automatic cpu_write(input logic [7:0] a, input logic [15:0] d);
        sel = 1'b1; rw = 1'b1; addr = a; din = d;
        tick();
        sel = 1'b0; rw = 1'b0; din = '0;
    endtask

    task automatic cpu_read(input logic [7:0] a, output logic [15:0] d);
        sel = 1'b1; rw = 1'b0; addr = a;
        tick();
        sel = 1'b0;
        d = dout;
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [15:0] exp);
        logic [15:0] d;
        cpu_read(a, d);
        chk(tag, 32'(d), 32'(exp));
    endtask

    // Channel c in mask sends base + 16*c + i for i in 0..n-1; returns at
    // the negedge where rx_vld is driven low (t_low = cyc at that point).
    task automatic send_pkts(input logic [3:0] mask, input int n, input logic [7:0] base,
                             output int t_low);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) begin
                if (mask[c]) begin
                    rxd[c*8 +: 8] = base + 8'(c * 16) + 8'(i);
                    rx_vld[c]     = 1'b1;
                end
            end
            tick();
        end
        rx_vld = rx_vld & ~mask;
        t_low  = cyc;
    endtask

    task automatic wait_tx(input string tag, input int n, input int budget);
        for (int k = 0; k < budget && txq.size() < n; k++) tick();
        chk(tag, 32'(txq.size()), 32'(n));
    endtask

    task automatic chk_word(input string tag, input int i, input int exp_cyc,
                            input int exp_ch, input int exp_data);
        txw_t w;
        w = txq_at(i);
        chk({tag, "_data"}, 32'(w.data), 32'(exp_data));
        chk({tag, "_ch"}, 32'(w.ch), 32'(exp_ch));
        if (exp_cyc >= 0) chk({tag, "_cyc"}, 32'(w.cyc), 32'(exp_cyc));
    endtask

    initial begin
        int   t;
        logic found;

        rst = 1'b1; sel = 1'b0; rw = 1'b0; addr = '0; din = '0;
        rxd = '0; rx_vld = '0;
        tick(3);
        chk("rst_dout", 32'(dout), 0);
        chk("rst_txvld", 32'(tx_vld), 0);
        chk("rst_txd", 32'(txd), 0);
        chk("rst_txch", 32'(tx_ch), 0);
        rst = 1'b0;
        tick();
        read_chk("rst_ctrl", 8'h00, 16'h0);
        read_chk("rst_status", 8'h01, 16'h0);
        read_chk("rst_rxcnt0", 8'h10, 16'h0);

        // Single 3-word packet on ch0; minimum latency.
        cpu_write(8'h00, 16'h1);
        read_chk("ctrl_rd", 8'h00, 16'h1);
        txq.delete();
        send_pkts(4'b0001, 3, 8'hA1, t);
        wait_tx("t1_cnt", 3, 20);
        chk_word("t1_w0", 0, t + 2, 0, 'hA1);
        chk_word("t1_w1", 1, t + 3, 0, 'hA2);
        chk_word("t1_w2", 2, t + 4, 0, 'hA3);
        read_chk("t1_rxcnt0", 8'h10, 16'h1);

        // Round-robin: ch1 granted first, then ch1/ch2 complete together.
        cpu_write(8'h00, 16'hF);
        tick(3);
        txq.delete();
        send_pkts(4'b0010, 2, 8'h00, t);
        wait_tx("t2a_cnt", 2, 20);
        chk_word("t2a_w0", 0, t + 2, 1, 'h10);
        tick(3);
        txq.delete();
        send_pkts(4'b0110, 2, 8'h40, t);
        tick();
        read_chk("t2_status", 8'h01, 16'h6);
        wait_tx("t2_cnt", 4, 30);
        chk_word("t2_w0", 0, t + 2, 2, 'h60);
        chk_word("t2_w1", 1, t + 3, 2, 'h61);
        chk_word("t2_w2", 2, t + 5, 1, 'h50);
        chk_word("t2_w3", 3, t + 6, 1, 'h51);

        // One-word packet.
        tick(3);
        txq.delete();
        send_pkts(4'b0100, 1, 8'h79, t);
        wait_tx("t2c_cnt", 1, 20);
        chk_word("t2c_w0", 0, t + 2, 2, 'h99);
        tick(3);
        chk("t2c_len", 32'(txq.size()), 1);
        read_chk("t2_rxcnt1", 8'h11, 16'h2);
        read_chk("t2_rxcnt2", 8'h12, 16'h2);

        // Oversize packet on ch3 dropped, following packet forwarded.
        txq.delete();
        send_pkts(4'b1000, 17, 8'h00, t);
        tick();
        send_pkts(4'b1000, 4, 8'h50, t);
        wait_tx("t3_cnt", 4, 40);
        chk_word("t3_w0", 0, t + 2, 3, 'h80);
        chk_word("t3_w3", 3, t + 5, 3, 'h83);
        tick(6);
        chk("t3_len", 32'(txq.size()), 4);
        read_chk("t3_drop3", 8'h23, 16'h1);
        read_chk("t3_rxcnt3", 8'h13, 16'h1);
        cpu_write(8'h23, 16'h1234);
        read_chk("t3_drop3_clr", 8'h23, 16'h0);
        read_chk("unmapped", 8'h40, 16'h0);

        // Disabled channel discards; enabling mid-packet still discards.
        cpu_write(8'h10, 16'h0);
        read_chk("t4_rxcnt0_clr", 8'h10, 16'h0);
        cpu_write(8'h00, 16'h0);
        txq.delete();
        send_pkts(4'b0001, 3, 8'h00, t);
        tick(10);
        chk("t4_no_tx", 32'(txq.size()), 0);
        read_chk("t4_rxcnt0", 8'h10, 16'h0);
        read_chk("t4_drop0", 8'h20, 16'h0);
        for (int i = 0; i < 4; i++) begin
            rxd[7:0]  = 8'hC0 + 8'(i);
            rx_vld[0] = 1'b1;
            if (i == 1) begin
                sel = 1'b1; rw = 1'b1; addr = 8'h00; din = 16'h1;
            end else begin
                sel = 1'b0; rw = 1'b0; din = '0;
            end
            tick();
        end
        rx_vld[0] = 1'b0;
        sel = 1'b0; rw = 1'b0;
        tick(10);
        chk("t4_mid_no_tx", 32'(txq.size()), 0);
        send_pkts(4'b0001, 2, 8'hD0, t);
        wait_tx("t4_cnt", 2, 20);
        chk_word("t4_w0", 0, t + 2, 0, 'hD0);
        chk_word("t4_w1", 1, t + 3, 0, 'hD1);
        read_chk("t4_rxcnt0_b", 8'h10, 16'h1);
        read_chk("t4_drop0_b", 8'h20, 16'h0);

        // Reset in the middle of sending a 5-word packet.
        tick(3);
        txq.delete();
        send_pkts(4'b0001, 5, 8'hE0, t);
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (tx_vld === 1'b1 && txd === 8'hE1) found = 1'b1;
            else tick();
        end
        chk("t5_seen_w1", 32'(found), 1);
        rst = 1'b1;
        tick();
        chk("t5_txvld", 32'(tx_vld), 0);
        chk("t5_txd", 32'(txd), 0);
        chk("t5_txch", 32'(tx_ch), 0);
        rst = 1'b0;
        read_chk("t5_status", 8'h01, 16'h0);
        read_chk("t5_rxcnt0", 8'h10, 16'h0);
        read_chk("t5_rxcnt1", 8'h11, 16'h0);
        read_chk("t5_ctrl", 8'h00, 16'h0);
        tick(10);
        chk("t5_len", 32'(txq.size()), 2);

`ifdef PKT_FWD_MC_PRIO_EN
        // Strict priority: ch0 wins again over ch3.
        cpu_write(8'h00, 16'h9);
        cpu_write(8'h02, 16'h1);
        read_chk("t6_prio", 8'h02, 16'h1);
        txq.delete();
        send_pkts(4'b0001, 1, 8'h11, t);
        wait_tx("t6a_cnt", 1, 20);
        tick(3);
        txq.delete();
        send_pkts(4'b1001, 2, 8'h00, t);
        wait_tx("t6_cnt", 4, 30);
        chk_word("t6_w0", 0, t + 2, 0, 'h00);
        chk_word("t6_w2", 2, t + 5, 3, 'h30);
`else
        cpu_write(8'h02, 16'h1);
        read_chk("t6_prio", 8'h02, 16'h0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
